// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage over a synchronous-read instruction ROM
// Word-addressed PC with stall hold, redirect, context switch and out-of-range fault.
module instruction_fetch #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ROM_SIZE      = 800,
    parameter int RESET_PC      = 200,
    parameter int SWITCH_VECTOR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  ctx_switch,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] saved_pc,
    output logic                  fetch_fault
);

    localparam logic [ADDR_WIDTH-1:0] ROM_LIMIT  = ADDR_WIDTH'(ROM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] SWITCH_PC  = ADDR_WIDTH'(SWITCH_VECTOR);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0] saved_pc_q, saved_pc_d;
    logic                  hold;

    assign fetch_fault = (pc_q >= ROM_LIMIT);
    assign hold        = stall && instr_valid_q && !ctx_switch && !redirect_valid;

    // While holding, re-read the presented address so rom_q (and instr) stays stable.
    assign rom_addr    = hold ? instr_pc_q : pc_q;
    assign instr       = rom_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign saved_pc    = saved_pc_q;

    always_comb begin
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        saved_pc_d    = saved_pc_q;
        if (ctx_switch) begin
            pc_d          = SWITCH_PC;
            instr_valid_d = 1'b0;
            if (redirect_valid)
                saved_pc_d = redirect_pc;
            else if (instr_valid_q)
                saved_pc_d = instr_pc_q;
            else
                saved_pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d          = redirect_pc;
            instr_valid_d = 1'b0;
        end else if (fetch_fault) begin
            instr_valid_d = 1'b0;
        end else if (!hold) begin
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_ADDR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            saved_pc_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            saved_pc_q    <= saved_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ctx_switch;
    logic [31:0] rom_addr;
    logic [31:0] rom_q;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] saved_pc;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ctx_switch(ctx_switch), .rom_addr(rom_addr), .rom_q(rom_q),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .saved_pc(saved_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) rom_q <= rom_f(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(32'(i));
    endtask

    task automatic wait_pc(input logic [31:0] t);
        for (int i = 0; i < 300; i++) begin
            if (instr_valid && instr_pc == t) return;
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_pc: instr_pc %0d never presented (last %0d)", t, instr_pc);
    endtask

    // Scoreboard: every consumed instruction must match the next expected PC and its ROM word.
    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall && !ctx_switch) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_consume: instr_pc %0d with empty queue", instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("consumed_pc", instr_pc, e);
                chk("consumed_instr", instr, rom_f(e));
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ctx_switch = 1'b0;
        #13;
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_saved_pc", saved_pc, 0);
        chk("rst_fault", 32'(fetch_fault), 0);
        chk("rst_rom_addr", rom_addr, 200);

        push_range(200, 210);
        step();
        rst_n = 1'b1;
        wait_pc(205);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rom_addr", rom_addr, 205);
            chk("stall_instr_pc", instr_pc, 205);
            chk("stall_instr", instr, rom_f(205));
            step();
        end
        stall = 1'b0;
        step();
        chk("after_stall_pc", instr_pc, 206);

        push_range(400, 449);
        wait_pc(210);
        redirect_valid = 1'b1; redirect_pc = 400;
        step();
        redirect_valid = 1'b0;
        chk("redir_bubble", 32'(instr_valid), 0);
        step();
        chk("redir_target", instr_pc, 400);

        push_range(0, 1);
        wait_pc(450);
        ctx_switch = 1'b1;
        step();
        ctx_switch = 1'b0;
        chk("ctx_saved_plain", saved_pc, 450);
        chk("ctx_bubble", 32'(instr_valid), 0);
        step();
        chk("ctx_vector", instr_pc, 0);
        wait_pc(1);
        redirect_valid = 1'b1; redirect_pc = 450;
        step();
        redirect_valid = 1'b0;
        wait_pc(450);
        chk("saved_unchanged", saved_pc, 450);
        ctx_switch = 1'b1; redirect_valid = 1'b1; redirect_pc = 420;
        step();
        ctx_switch = 1'b0; redirect_valid = 1'b0;
        chk("ctx_saved_redir", saved_pc, 420);

        exp_q.push_back(0);
        push_range(795, 799);
        wait_pc(0);
        redirect_valid = 1'b1; redirect_pc = 795;
        step();
        redirect_valid = 1'b0;
        wait_pc(799);
        chk("fault_at_end", 32'(fetch_fault), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_held", 32'(fetch_fault), 1);
            chk("fault_no_valid", 32'(instr_valid), 0);
        end
        push_range(600, 604);
        redirect_valid = 1'b1; redirect_pc = 600;
        step();
        redirect_valid = 1'b0;
        chk("fault_cleared", 32'(fetch_fault), 0);
        chk("fault_clear_bubble", 32'(instr_valid), 0);
        step();
        chk("fault_resume_pc", instr_pc, 600);

        push_range(610, 612);
        wait_pc(604);
        redirect_valid = 1'b1; redirect_pc = 900;
        step();
        chk("oob_redirect_fault", 32'(fetch_fault), 1);
        redirect_pc = 610;
        step();
        redirect_valid = 1'b0;
        chk("oob_recovered", 32'(fetch_fault), 0);
        wait_pc(612);
        redirect_valid = 1'b1; redirect_pc = 520;
        step();
        redirect_valid = 1'b0;
        wait_pc(520);
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 0);
        chk("midrst_instr_pc", instr_pc, 0);
        chk("midrst_saved_pc", saved_pc, 0);
        chk("midrst_rom_addr", rom_addr, 200);
        chk("midrst_fault", 32'(fetch_fault), 0);

        push_range(200, 204);
        step();
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        chk("restart_pc", instr_pc, 200);
        wait_pc(205);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
